// File: rtl/party_gfx_pkg.sv
// Shared types and constants for the party graphics video path.
package party_gfx_pkg;

    localparam logic [4:0] TRANSPARENT_IDX = 5'd0;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int COORD_W  = $clog2((SCREEN_W > SCREEN_H) ? SCREEN_W : SCREEN_H);

    typedef logic [4:0]         pal_idx_t;
    typedef logic [COORD_W-1:0] spr_coord_t;

    // Offset of a screen coordinate from a sprite origin, one bit wider than a
    // coordinate so a pixel left of / above the origin wraps to a large value.
    function automatic logic [COORD_W:0] coord_offset(input spr_coord_t pos, input spr_coord_t origin);
        return {1'b0, pos} - {1'b0, origin};
    endfunction

endpackage

// File: rtl/sprite_rom.sv
// Sprite image store: synchronous read with clock enable, one word per pixel
// for every animation frame. The image is placed in mem by the platform's
// memory-initialisation flow for each instance.
module sprite_rom
    import party_gfx_pkg::*;
#(
    parameter int DEPTH = 4096,
    parameter int AW    = 12
) (
    input  logic          clk,
    input  logic          ce,
    input  logic [AW-1:0] addr,
    output pal_idx_t      data
);

    pal_idx_t mem [DEPTH] = '{default: TRANSPARENT_IDX};

    // Registered read that advances only with the pixel enable.
    always_ff @(posedge clk) begin
        if (ce) begin
            data <= mem[addr];
        end
    end

endmodule

// File: rtl/sprite_index_fetch.sv
// Sprite compositor: three-stage pixel pipeline producing the palette index
// for each drawn pixel, with frame-start shadowing of sprite attributes.
module sprite_index_fetch
    import party_gfx_pkg::*;
#(
    parameter int NUM_SPR  = 4,
    parameter int SPR_W    = 32,
    parameter int SPR_H    = 32,
    parameter int FRAMES   = 4,
    parameter int ANIM_DIV = 8
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  frame_start,
    input  logic                  pix_ce,
    input  logic [9:0]            DrawX,
    input  logic [9:0]            DrawY,
    input  logic [NUM_SPR*10-1:0] spr_x,
    input  logic [NUM_SPR*10-1:0] spr_y,
    input  logic [NUM_SPR-1:0]    spr_en,
    input  logic [NUM_SPR-1:0]    spr_flip,
    input  logic [4:0]            bg_index,
    output logic [4:0]            pal_index,
    output logic                  pix_valid,
    output logic [NUM_SPR-1:0]    hit_mask
);

    localparam int XW    = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int DEPTH = FRAMES * SPR_W * SPR_H;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int FW    = (FRAMES > 1) ? $clog2(FRAMES) : 1;
    localparam int DW    = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

    logic [NUM_SPR*10-1:0] sh_x_r;
    logic [NUM_SPR*10-1:0] sh_y_r;
    logic [NUM_SPR-1:0]    sh_en_r;
    logic [NUM_SPR-1:0]    sh_flip_r;
    logic [DW-1:0]         div_cnt_r;
    logic [FW-1:0]         anim_frame_r;

    logic [NUM_SPR-1:0]    inside_s;
    logic [AW-1:0]         addr_s [NUM_SPR];
    logic [AW-1:0]         addr_r [NUM_SPR];
    logic                  valid0_r;
    logic                  valid1_r;
    pal_idx_t              bg0_r;
    pal_idx_t              bg1_r;
    logic [NUM_SPR-1:0]    inside0_r;
    logic [NUM_SPR-1:0]    inside1_r;
    pal_idx_t              rom_data_s [NUM_SPR];
    logic [NUM_SPR-1:0]    opaque_s;
    pal_idx_t              comp_idx_s;

    // Per-sprite hit test and ROM address from the shadowed attributes.
    for (genvar i = 0; i < NUM_SPR; i++) begin : g_spr
        logic [10:0]   dx_s;
        logic [10:0]   dy_s;
        logic [XW-1:0] col_s;

        assign dx_s        = coord_offset(DrawX, sh_x_r[10*i +: 10]);
        assign dy_s        = coord_offset(DrawY, sh_y_r[10*i +: 10]);
        assign inside_s[i] = sh_en_r[i] && (dx_s < 11'(SPR_W)) && (dy_s < 11'(SPR_H));
        assign col_s       = sh_flip_r[i] ? (XW'(SPR_W - 1) - dx_s[XW-1:0]) : dx_s[XW-1:0];
        assign addr_s[i]   = AW'(anim_frame_r) * AW'(SPR_W * SPR_H)
                           + AW'(dy_s) * AW'(SPR_W) + AW'(col_s);

        sprite_rom #(
            .DEPTH (DEPTH),
            .AW    (AW)
        ) u_rom (
            .clk  (Clk),
            .ce   (pix_ce),
            .addr (addr_r[i]),
            .data (rom_data_s[i])
        );
    end

    // Shadow sprite attributes and step the shared animation timebase at frame start.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            sh_x_r       <= '0;
            sh_y_r       <= '0;
            sh_en_r      <= '0;
            sh_flip_r    <= '0;
            div_cnt_r    <= '0;
            anim_frame_r <= '0;
        end else if (frame_start) begin
            sh_x_r    <= spr_x;
            sh_y_r    <= spr_y;
            sh_en_r   <= spr_en;
            sh_flip_r <= spr_flip;
            if (div_cnt_r == DW'(ANIM_DIV - 1)) begin
                div_cnt_r <= '0;
                if (anim_frame_r == FW'(FRAMES - 1)) begin
                    anim_frame_r <= '0;
                end else begin
                    anim_frame_r <= anim_frame_r + FW'(1);
                end
            end else begin
                div_cnt_r <= div_cnt_r + DW'(1);
            end
        end
    end

    // Stage 0: capture ROM addresses, hit flags and background for the sampled pixel.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            valid0_r  <= 1'b0;
            bg0_r     <= TRANSPARENT_IDX;
            inside0_r <= '0;
            for (int i = 0; i < NUM_SPR; i++) begin
                addr_r[i] <= '0;
            end
        end else if (pix_ce) begin
            valid0_r  <= 1'b1;
            bg0_r     <= bg_index;
            inside0_r <= inside_s;
            for (int i = 0; i < NUM_SPR; i++) begin
                addr_r[i] <= addr_s[i];
            end
        end
    end

    // Stage 1: delay side information to line up with the ROM read data.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            valid1_r  <= 1'b0;
            bg1_r     <= TRANSPARENT_IDX;
            inside1_r <= '0;
        end else if (pix_ce) begin
            valid1_r  <= valid0_r;
            bg1_r     <= bg0_r;
            inside1_r <= inside0_r;
        end
    end

    // Stage 2 combine: opaque flags and fixed-priority pick, sprite 0 on top.
    always_comb begin
        opaque_s   = '0;
        comp_idx_s = bg1_r;
        for (int i = NUM_SPR - 1; i >= 0; i--) begin
            opaque_s[i] = inside1_r[i] && (rom_data_s[i] != TRANSPARENT_IDX);
            comp_idx_s  = opaque_s[i] ? rom_data_s[i] : comp_idx_s;
        end
    end

    // Stage 2 register: outputs change only on a pixel enable once the pipe is full.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pal_index <= TRANSPARENT_IDX;
            pix_valid <= 1'b0;
            hit_mask  <= '0;
        end else begin
            pix_valid <= pix_ce && valid1_r;
            if (pix_ce && valid1_r) begin
                pal_index <= comp_idx_s;
                hit_mask  <= opaque_s;
            end
        end
    end

endmodule

// File: tb/tb_sprite_index_fetch.sv
// Bench for sprite_index_fetch: directed pixel probes plus randomized traffic
// checked by a pixel-level reference model with a three-sample delay queue.
module tb_sprite_index_fetch;

    localparam int NUM_SPR  = 4;
    localparam int SPR_W    = 32;
    localparam int SPR_H    = 32;
    localparam int FRAMES   = 4;
    localparam int ANIM_DIV = 2;
    localparam int DEPTH    = FRAMES * SPR_W * SPR_H;

    logic                  Clk;
    logic                  Reset;
    logic                  frame_start;
    logic                  pix_ce;
    logic [9:0]            DrawX;
    logic [9:0]            DrawY;
    logic [NUM_SPR*10-1:0] spr_x;
    logic [NUM_SPR*10-1:0] spr_y;
    logic [NUM_SPR-1:0]    spr_en;
    logic [NUM_SPR-1:0]    spr_flip;
    logic [4:0]            bg_index;
    logic [4:0]            pal_index;
    logic                  pix_valid;
    logic [NUM_SPR-1:0]    hit_mask;

    sprite_index_fetch #(
        .NUM_SPR  (NUM_SPR),
        .SPR_W    (SPR_W),
        .SPR_H    (SPR_H),
        .FRAMES   (FRAMES),
        .ANIM_DIV (ANIM_DIV)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .frame_start (frame_start),
        .pix_ce      (pix_ce),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .spr_x       (spr_x),
        .spr_y       (spr_y),
        .spr_en      (spr_en),
        .spr_flip    (spr_flip),
        .bg_index    (bg_index),
        .pal_index   (pal_index),
        .pix_valid   (pix_valid),
        .hit_mask    (hit_mask)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: sprite images, shadowed attributes, frame count.
    logic [4:0] rom_img [NUM_SPR][DEPTH];
    int         m_x [NUM_SPR];
    int         m_y [NUM_SPR];
    bit         m_en [NUM_SPR];
    bit         m_flip [NUM_SPR];
    int         m_frames;
    int         exp_pal_q [$];
    int         exp_hit_q [$];
    int         last_pal;
    int         last_hit;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected output for one pixel, straight from the compositing rules.
    function automatic void model_pixel(input int x, input int y, input int bg,
                                        output int pal, output int hit);
        int  anim, dx, dy, col, v;
        bit  found;
        anim  = (m_frames / ANIM_DIV) % FRAMES;
        pal   = bg;
        hit   = 0;
        found = 1'b0;
        for (int i = 0; i < NUM_SPR; i++) begin
            dx = x - m_x[i];
            dy = y - m_y[i];
            if (m_en[i] && dx >= 0 && dx < SPR_W && dy >= 0 && dy < SPR_H) begin
                col = m_flip[i] ? (SPR_W - 1 - dx) : dx;
                v   = int'(rom_img[i][anim * SPR_W * SPR_H + dy * SPR_W + col]);
                if (v != 0) begin
                    hit = hit | (1 << i);
                    if (!found) begin
                        pal   = v;
                        found = 1'b1;
                    end
                end
            end
        end
    endfunction

    // Scoreboard: sample inputs on each edge, check outputs just after it.
    bit mon_ce;
    int mp, mh;
    always @(posedge Clk) begin
        if (Reset) begin
            exp_pal_q.delete();
            exp_hit_q.delete();
            last_pal = 0;
            last_hit = 0;
            m_frames = 0;
            for (int i = 0; i < NUM_SPR; i++) begin
                m_x[i] = 0; m_y[i] = 0; m_en[i] = 1'b0; m_flip[i] = 1'b0;
            end
            #1;
            check_eq("rst_pal", pal_index, 0);
            check_eq("rst_valid", pix_valid, 0);
            check_eq("rst_hit", hit_mask, 0);
        end else begin
            mon_ce = pix_ce;
            if (pix_ce) begin
                model_pixel(int'(DrawX), int'(DrawY), int'(bg_index), mp, mh);
                exp_pal_q.push_back(mp);
                exp_hit_q.push_back(mh);
            end
            if (frame_start) begin
                for (int i = 0; i < NUM_SPR; i++) begin
                    m_x[i]    = int'(spr_x[10*i +: 10]);
                    m_y[i]    = int'(spr_y[10*i +: 10]);
                    m_en[i]   = spr_en[i];
                    m_flip[i] = spr_flip[i];
                end
                m_frames++;
            end
            #1;
            if (mon_ce && exp_pal_q.size() == 3) begin
                last_pal = exp_pal_q.pop_front();
                last_hit = exp_hit_q.pop_front();
                check_eq("sb_valid", pix_valid, 1);
                check_eq("sb_pal", pal_index, last_pal);
                check_eq("sb_hit", hit_mask, last_hit);
            end else begin
                check_eq("idle_valid", pix_valid, 0);
                check_eq("hold_pal", pal_index, last_pal);
                check_eq("hold_hit", hit_mask, last_hit);
            end
        end
    end

    task automatic set_spr(input int i, input int x, input int y, input bit en, input bit flip);
        spr_x[10*i +: 10] = 10'(x);
        spr_y[10*i +: 10] = 10'(y);
        spr_en[i]         = en;
        spr_flip[i]       = flip;
    endtask

    task automatic clear_all();
        for (int i = 0; i < NUM_SPR; i++) begin
            set_spr(i, 0, 0, 1'b0, 1'b0);
            for (int a = 0; a < DEPTH; a++) rom_img[i][a] = 5'd0;
        end
    endtask

    task automatic load_roms();
        for (int a = 0; a < DEPTH; a++) begin
            dut.g_spr[0].u_rom.mem[a] = rom_img[0][a];
            dut.g_spr[1].u_rom.mem[a] = rom_img[1][a];
            dut.g_spr[2].u_rom.mem[a] = rom_img[2][a];
            dut.g_spr[3].u_rom.mem[a] = rom_img[3][a];
        end
    endtask

    task automatic reset_and_load();
        Reset = 1'b1;
        repeat (2) @(negedge Clk);
        load_roms();
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        @(negedge Clk);
        frame_start = 1'b0;
        @(negedge Clk);
    endtask

    // Hold one pixel through three enables, then compare against fixed values.
    task automatic probe(input string tag, input int x, input int y, input int bg,
                         input int exp_pal, input int exp_hit);
        DrawX    = 10'(x);
        DrawY    = 10'(y);
        bg_index = 5'(bg);
        repeat (3) begin
            pix_ce = 1'b1;
            @(negedge Clk);
            pix_ce = 1'b0;
            @(negedge Clk);
        end
        check_eq({tag, "_pal"}, pal_index, exp_pal);
        check_eq({tag, "_hit"}, hit_mask, exp_hit);
    endtask

    int rx, ry, rs;

    initial begin
        Reset = 1'b1; frame_start = 1'b0; pix_ce = 1'b0;
        DrawX = 10'd0; DrawY = 10'd0; bg_index = 5'd0;
        spr_x = '0; spr_y = '0; spr_en = '0; spr_flip = '0;
        clear_all();
        repeat (3) @(negedge Clk);
        check_eq("rst_pal_direct", pal_index, 0);
        Reset = 1'b0;
        @(negedge Clk);

        // Pipeline fill: valid only from the third enable.
        for (int k = 1; k <= 4; k++) begin
            bg_index = 5'($urandom_range(0, 31));
            pix_ce   = 1'b1;
            @(negedge Clk);
            check_eq("fill_valid", pix_valid, (k >= 3) ? 1 : 0);
            pix_ce = 1'b0;
            @(negedge Clk);
        end

        // Single opaque sprite over background.
        clear_all();
        for (int a = 0; a < DEPTH; a++) rom_img[0][a] = 5'd7;
        set_spr(0, 100, 50, 1'b1, 1'b0);
        reset_and_load();
        pulse_frame();
        probe("spr_hit", 100, 50, 3, 7, 1);
        probe("spr_left", 99, 50, 3, 3, 0);
        probe("spr_right", 132, 50, 3, 3, 0);
        probe("spr_corner", 131, 81, 3, 7, 1);

        // Tear-free attribute update.
        set_spr(0, 300, 50, 1'b1, 1'b0);
        probe("tear_old", 100, 50, 3, 7, 1);
        probe("tear_new_early", 300, 50, 3, 3, 0);
        pulse_frame();
        probe("tear_new", 300, 50, 3, 7, 1);
        probe("tear_old_gone", 100, 50, 3, 3, 0);

        // Transparency and priority.
        clear_all();
        rom_img[0][0] = 5'd0;
        rom_img[1][0] = 5'd5;
        set_spr(0, 200, 200, 1'b1, 1'b0);
        set_spr(1, 200, 200, 1'b1, 1'b0);
        reset_and_load();
        pulse_frame();
        probe("prio_transp", 200, 200, 3, 5, 2);
        rom_img[0][0] = 5'd9;
        reset_and_load();
        pulse_frame();
        probe("prio_top", 200, 200, 3, 9, 3);

        // Horizontal mirror over a ramp row.
        clear_all();
        for (int f = 0; f < FRAMES; f++)
            for (int c = 0; c < SPR_W; c++) rom_img[0][f * SPR_W * SPR_H + c] = 5'(c);
        set_spr(0, 300, 100, 1'b1, 1'b1);
        reset_and_load();
        pulse_frame();
        probe("flip_first", 300, 100, 0, 31, 1);
        probe("flip_last", 331, 100, 0, 0, 0);

        // Screen-edge clipping and far-off-screen sprite.
        clear_all();
        for (int a = 0; a < DEPTH; a++) begin
            rom_img[2][a] = 5'd6;
            rom_img[3][a] = 5'd8;
        end
        set_spr(2, 630, 20, 1'b1, 1'b0);
        set_spr(3, 1020, 20, 1'b1, 1'b0);
        reset_and_load();
        pulse_frame();
        probe("edge_clip", 639, 20, 4, 6, 4);
        probe("edge_far0", 0, 20, 4, 4, 0);
        probe("edge_far5", 5, 20, 4, 4, 0);

        // Animation: each frame image holds its own frame number plus one.
        clear_all();
        for (int f = 0; f < FRAMES; f++)
            for (int a = 0; a < SPR_W * SPR_H; a++) rom_img[0][f * SPR_W * SPR_H + a] = 5'(f + 1);
        set_spr(0, 10, 10, 1'b1, 1'b0);
        reset_and_load();
        pulse_frame();
        probe("anim_p1", 10, 10, 0, 1, 1);
        pulse_frame();
        probe("anim_p2", 10, 10, 0, 2, 1);
        pulse_frame();
        probe("anim_p3", 10, 10, 0, 2, 1);
        pulse_frame();
        probe("anim_p4", 10, 10, 0, 3, 1);

        // Randomized traffic against the scoreboard.
        for (int i = 0; i < NUM_SPR; i++)
            for (int a = 0; a < DEPTH; a++)
                rom_img[i][a] = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        set_spr(0, $urandom_range(0, 600), $urandom_range(0, 440), 1'b1, 1'b0);
        set_spr(1, $urandom_range(0, 600), $urandom_range(0, 440), 1'b1, 1'b1);
        set_spr(2, 630, $urandom_range(0, 440), 1'b1, 1'b0);
        set_spr(3, 1020, $urandom_range(0, 440), 1'b1, 1'b0);
        reset_and_load();
        pulse_frame();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            rs = $urandom_range(0, NUM_SPR - 1);
            rx = int'(spr_x[10*rs +: 10]) + $urandom_range(0, 40) - 4;
            ry = int'(spr_y[10*rs +: 10]) + $urandom_range(0, 40) - 4;
            if (rx < 0 || rx > 639) rx = $urandom_range(0, 639);
            if (ry < 0 || ry > 479) ry = $urandom_range(0, 479);
            DrawX       = 10'(rx);
            DrawY       = 10'(ry);
            bg_index    = 5'($urandom_range(0, 31));
            pix_ce      = 1'($urandom_range(0, 1));
            frame_start = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 63) == 0)
                set_spr($urandom_range(0, NUM_SPR - 1), $urandom_range(0, 1023),
                        $urandom_range(0, 479), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            Reset = ($urandom_range(0, 499) == 0);
            @(negedge Clk);
        end
        Reset = 1'b0; pix_ce = 1'b0; frame_start = 1'b0;
        repeat (4) @(negedge Clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
